// File: rtl/nv_csa_pkg.sv
// nv_csa_pkg
//   Shared helpers for the carry-save reduction tree.
//   - csa_word_t / csa_pair_t : fixed 64-bit working words. Callers zero-pad
//     narrower operands and keep only their low bits. Any carry shifted past
//     their width is dropped, which matches the mod-2^W arithmetic.
//   - csa32        : one 3:2 counter over three words.
//   - csa_next     : operand count after one 3:2 level (n - n/3).
//   - csa_levels   : number of 3:2 levels needed to reach two operands.
//   - csa_count_at : operand count after k levels.
//   - csa_reg_after: 1 when a pipeline register follows a given level.
//                    Registers sit after levels ceil(k*L/(P+1)), k = 1..P.
package nv_csa_pkg;

    localparam int CSA_W = 64;

    typedef logic [CSA_W-1:0] csa_word_t;

    typedef struct packed {
        csa_word_t sum;
        csa_word_t carry;
    } csa_pair_t;

    function automatic csa_pair_t csa32(input csa_word_t a, input csa_word_t b,
                                       input csa_word_t c);
        csa_pair_t p;
        p.sum   = a ^ b ^ c;
        p.carry = ((a & b) | (a & c) | (b & c)) << 1;
        return p;
    endfunction

    function automatic int csa_next(input int n);
        return n - n / 3;
    endfunction

    function automatic int csa_levels(input int n);
        int m;
        int l;
        m = n;
        l = 0;
        while (m > 2) begin
            m = csa_next(m);
            l++;
        end
        return l;
    endfunction

    function automatic int csa_count_at(input int n, input int k);
        int m;
        m = n;
        for (int i = 0; i < k; i++) m = csa_next(m);
        return m;
    endfunction

    function automatic bit csa_reg_after(input int lvl, input int levels, input int stages);
        for (int k = 1; k <= stages; k++) begin
            if ((k * levels + stages) / (stages + 1) == lvl) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/nv_csa_tree_acc_if.sv
// nv_csa_tree_acc_if
//   Beat input and result output of nv_csa_tree_acc.
//   Handshake: a beat transfers on a rising clock edge where in_pvld and
//   in_prdy are both 1, and likewise a result transfers when out_pvld and
//   out_prdy are both 1. A source holds its payload steady while valid is high
//   and ready is low. in_prdy may depend combinationally on out_prdy.
//   Ports:
//     in_pvld/in_prdy, in_data (operand i at [i*IN_WIDTH +: IN_WIDTH]),
//     in_first/in_last delimit a group;
//     out_pvld/out_prdy, out_sum (group sum mod 2^OUT_WIDTH), out_cnt (beats,
//     saturating).
//   master = beat producer / result consumer; slave = the accumulator.
interface nv_csa_tree_acc_if #(
    parameter int NUM_INPUTS = 8,
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
);
    logic                           in_pvld;
    logic                           in_prdy;
    logic [NUM_INPUTS*IN_WIDTH-1:0] in_data;
    logic                           in_first;
    logic                           in_last;
    logic                           out_pvld;
    logic                           out_prdy;
    logic [OUT_WIDTH-1:0]           out_sum;
    logic [CNT_WIDTH-1:0]           out_cnt;

    modport master (
        output in_pvld, in_data, in_first, in_last, out_prdy,
        input  in_prdy, out_pvld, out_sum, out_cnt
    );

    modport slave (
        input  in_pvld, in_data, in_first, in_last, out_prdy,
        output in_prdy, out_pvld, out_sum, out_cnt
    );
endinterface

// File: rtl/nv_csa_level.sv
// nv_csa_level
//   One combinational 3:2 reduction level.
//   Ports:
//     in_vec  : N_IN words of WIDTH bits, word i at [i*WIDTH +: WIDTH]
//     out_vec : csa_next(N_IN) words. Group g of three inputs yields its
//               sum at word 2g and its carry at word 2g+1. The N_IN%3
//               leftover inputs follow unchanged.
module nv_csa_level
    import nv_csa_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = 16
) (
    input  logic [N_IN*WIDTH-1:0]           in_vec,
    output logic [csa_next(N_IN)*WIDTH-1:0] out_vec
);
    localparam int N_GRP = N_IN / 3;
    localparam int N_REM = N_IN % 3;

    csa_word_t w_a;
    csa_word_t w_b;
    csa_word_t w_c;
    csa_pair_t p;

    always_comb begin
        out_vec = '0;
        w_a     = '0;
        w_b     = '0;
        w_c     = '0;
        p       = '0;
        for (int g = 0; g < N_GRP; g++) begin
            w_a = '0;
            w_b = '0;
            w_c = '0;
            w_a[WIDTH-1:0] = in_vec[(3*g)*WIDTH +: WIDTH];
            w_b[WIDTH-1:0] = in_vec[(3*g+1)*WIDTH +: WIDTH];
            w_c[WIDTH-1:0] = in_vec[(3*g+2)*WIDTH +: WIDTH];
            p = csa32(w_a, w_b, w_c);
            // Truncation drops the carry bit shifted out of the top.
            out_vec[(2*g)*WIDTH +: WIDTH]   = p.sum[WIDTH-1:0];
            out_vec[(2*g+1)*WIDTH +: WIDTH] = p.carry[WIDTH-1:0];
        end
        for (int r = 0; r < N_REM; r++) begin
            out_vec[(2*N_GRP+r)*WIDTH +: WIDTH] = in_vec[(3*N_GRP+r)*WIDTH +: WIDTH];
        end
    end
endmodule

// File: rtl/nv_csa_tree_acc.sv
// nv_csa_tree_acc
//   Pipelined carry-save reduction of NUM_INPUTS operands per beat. The tree
//   output is accumulated over a first/last group and resolved by a
//   carry-propagate add.
//   Ports:
//     nvdla_core_clk  : clock
//     nvdla_core_rstn : asynchronous active-low reset
//     io              : beat/result handshake bundle (nv_csa_tree_acc_if.slave)
//   A beat accepted at edge E0 reaches the accumulator at E0+PIPE_STAGES.
//   Its result is visible after E0+PIPE_STAGES+1. A single global enable
//   freezes every register while a result waits for out_prdy.
module nv_csa_tree_acc
    import nv_csa_pkg::*;
#(
    parameter int NUM_INPUTS  = 8,
    parameter int IN_WIDTH    = 8,
    parameter int OUT_WIDTH   = 16,   // 1..64
    parameter int PIPE_STAGES = 2,
    parameter int SIGNED_IN   = 0,
    parameter int CNT_WIDTH   = 8
) (
    input logic              nvdla_core_clk,
    input logic              nvdla_core_rstn,
    nv_csa_tree_acc_if.slave io
);
    localparam int LEVELS = csa_levels(NUM_INPUTS);

    logic                 en;
    logic                 out_pvld_q;
    logic [OUT_WIDTH-1:0] out_sum_q;
    logic [CNT_WIDTH-1:0] out_cnt_q;

    assign en          = !out_pvld_q || io.out_prdy;
    assign io.in_prdy  = en;
    assign io.out_pvld = out_pvld_q;
    assign io.out_sum  = out_sum_q;
    assign io.out_cnt  = out_cnt_q;

    // Operand extension to the working width.
    logic [NUM_INPUTS*OUT_WIDTH-1:0] ext_data;
    always_comb begin
        ext_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SIGNED_IN != 0)
                ext_data[i*OUT_WIDTH +: OUT_WIDTH] =
                    OUT_WIDTH'($signed(io.in_data[i*IN_WIDTH +: IN_WIDTH]));
            else
                ext_data[i*OUT_WIDTH +: OUT_WIDTH] =
                    OUT_WIDTH'(io.in_data[i*IN_WIDTH +: IN_WIDTH]);
        end
    end

    // Reduction levels. A level is followed by a register stage or by wires.
    for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
        localparam int N_IN  = csa_count_at(NUM_INPUTS, j - 1);
        localparam int N_OUT = csa_next(N_IN);

        logic [N_IN*OUT_WIDTH-1:0]  d_data;
        logic                       d_vld, d_first, d_last;
        logic [N_OUT*OUT_WIDTH-1:0] lvl_out;
        logic [N_OUT*OUT_WIDTH-1:0] q_data;
        logic                       q_vld, q_first, q_last;

        if (j == 1) begin : g_src
            assign d_data  = ext_data;
            assign d_vld   = io.in_pvld;
            assign d_first = io.in_first;
            assign d_last  = io.in_last;
        end else begin : g_src
            assign d_data  = g_lvl[j-1].q_data;
            assign d_vld   = g_lvl[j-1].q_vld;
            assign d_first = g_lvl[j-1].q_first;
            assign d_last  = g_lvl[j-1].q_last;
        end

        nv_csa_level #(.N_IN(N_IN), .WIDTH(OUT_WIDTH)) u_level (
            .in_vec  (d_data),
            .out_vec (lvl_out)
        );

        if (csa_reg_after(j, LEVELS, PIPE_STAGES)) begin : g_reg
            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    q_vld   <= 1'b0;
                    q_first <= 1'b0;
                    q_last  <= 1'b0;
                    q_data  <= '0;
                end else if (en) begin
                    q_vld   <= d_vld;
                    q_first <= d_first;
                    q_last  <= d_last;
                    q_data  <= lvl_out;
                end
            end
        end else begin : g_wire
            assign q_vld   = d_vld;
            assign q_first = d_first;
            assign q_last  = d_last;
            assign q_data  = lvl_out;
        end
    end

    logic [OUT_WIDTH-1:0] tree0, tree1;
    logic                 tail_vld, tail_first, tail_last;
    assign tree0      = g_lvl[LEVELS].q_data[OUT_WIDTH-1:0];
    assign tree1      = g_lvl[LEVELS].q_data[2*OUT_WIDTH-1:OUT_WIDTH];
    assign tail_vld   = g_lvl[LEVELS].q_vld;
    assign tail_first = g_lvl[LEVELS].q_first;
    assign tail_last  = g_lvl[LEVELS].q_last;

    // Accumulator: a 4:2 compression (two chained 3:2 counters) folds the
    // new tree pair into the held carry-save pair.
    logic [OUT_WIDTH-1:0] acc0, acc1, acc0_next, acc1_next;
    logic [CNT_WIDTH-1:0] acc_cnt, cnt_next;
    csa_word_t            w_a, w_b, w_c, w_d;
    csa_pair_t            p_lo, p_hi;

    always_comb begin
        w_a = '0;
        w_b = '0;
        w_c = '0;
        w_d = '0;
        w_a[OUT_WIDTH-1:0] = acc0;
        w_b[OUT_WIDTH-1:0] = acc1;
        w_c[OUT_WIDTH-1:0] = tree0;
        w_d[OUT_WIDTH-1:0] = tree1;
        p_lo = csa32(w_a, w_b, w_c);
        p_hi = csa32(p_lo.sum, p_lo.carry, w_d);
        if (tail_first) begin
            acc0_next = tree0;
            acc1_next = tree1;
            cnt_next  = CNT_WIDTH'(1);
        end else begin
            acc0_next = p_hi.sum[OUT_WIDTH-1:0];
            acc1_next = p_hi.carry[OUT_WIDTH-1:0];
            cnt_next  = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_WIDTH'(1);
        end
    end

    // The carry-save result of a closing beat is parked for one cycle so the
    // carry-propagate add has a stage of its own before the output register.
    logic                 res_vld;
    logic [OUT_WIDTH-1:0] res0, res1;
    logic [CNT_WIDTH-1:0] res_cnt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            acc0       <= '0;
            acc1       <= '0;
            acc_cnt    <= '0;
            res_vld    <= 1'b0;
            res0       <= '0;
            res1       <= '0;
            res_cnt    <= '0;
            out_pvld_q <= 1'b0;
            out_sum_q  <= '0;
            out_cnt_q  <= '0;
        end else if (en) begin
            if (tail_vld) begin
                if (tail_last) begin
                    // The group closes, so the next group starts from zero.
                    acc0    <= '0;
                    acc1    <= '0;
                    acc_cnt <= '0;
                    res0    <= acc0_next;
                    res1    <= acc1_next;
                    res_cnt <= cnt_next;
                end else begin
                    acc0    <= acc0_next;
                    acc1    <= acc1_next;
                    acc_cnt <= cnt_next;
                end
            end
            res_vld    <= tail_vld && tail_last;
            out_pvld_q <= res_vld;
            if (res_vld) begin
                out_sum_q <= res0 + res1;
                out_cnt_q <= res_cnt;
            end
        end
    end
endmodule

// File: tb/tb_nv_csa_tree_acc.sv
module tb_nv_csa_tree_acc;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nv_csa_tree_acc_if #(.NUM_INPUTS(8), .IN_WIDTH(8), .OUT_WIDTH(16), .CNT_WIDTH(8)) io ();
    nv_csa_tree_acc_if #(.NUM_INPUTS(8), .IN_WIDTH(8), .OUT_WIDTH(16), .CNT_WIDTH(8)) sio ();

    nv_csa_tree_acc #(
        .NUM_INPUTS(8), .IN_WIDTH(8), .OUT_WIDTH(16),
        .PIPE_STAGES(2), .SIGNED_IN(0), .CNT_WIDTH(8)
    ) u_dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .io              (io)
    );

    nv_csa_tree_acc #(
        .NUM_INPUTS(8), .IN_WIDTH(8), .OUT_WIDTH(16),
        .PIPE_STAGES(2), .SIGNED_IN(1), .CNT_WIDTH(8)
    ) u_dut_s (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .io              (sio)
    );

    // ---------------- scoreboard state ----------------
    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [23:0] exp_q[$];      // {cnt[7:0], sum[15:0]}
    logic [23:0] mon_exp;

    typedef struct {
        logic [63:0] data;
        int          beats;
        bit          use_first;
        logic [15:0] exp_sum;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Result monitor: every accepted result must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && io.out_pvld && io.out_prdy) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                err_cnt++;
                $display("FAIL unexpected_result: actual sum=0x%0h cnt=%0d required=no result",
                         io.out_sum, io.out_cnt);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_sum", 32'(io.out_sum), 32'(mon_exp[15:0]));
                check("result_cnt", 32'(io.out_cnt), 32'(mon_exp[23:16]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end one time unit after a rising edge.
    task automatic send_beat(input logic [63:0] d, input logic f, input logic l);
        logic ok;
        int   waited;
        waited      = 0;
        io.in_pvld  = 1'b1;
        io.in_data  = d;
        io.in_first = f;
        io.in_last  = l;
        forever begin
            @(negedge clk);
            ok = io.in_prdy;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 200) begin
                check("beat_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        io.in_pvld  = 1'b0;
        io.in_first = 1'b0;
        io.in_last  = 1'b0;
    endtask

    task automatic send_group(input logic [63:0] d, input int beats, input bit use_first);
        for (int b = 0; b < beats; b++)
            send_beat(d, use_first && (b == 0), b == beats - 1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic signed_beat(input logic [63:0] d, input logic [15:0] es);
        int w;
        w            = 0;
        sio.in_pvld  = 1'b1;
        sio.in_data  = d;
        sio.in_first = 1'b1;
        sio.in_last  = 1'b1;
        @(posedge clk);
        #1;
        sio.in_pvld  = 1'b0;
        while (!sio.out_pvld && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("signed_pvld", 32'(sio.out_pvld), 32'd1);
        check("signed_sum", 32'(sio.out_sum), 32'(es));
        check("signed_cnt", 32'(sio.out_cnt), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1,  1'b1, 16'h07F8, 8'd1};
        vecs[1] = '{64'h0101_0101_0101_0101, 3,  1'b1, 16'h0018, 8'd3};
        vecs[2] = '{64'h0807_0605_0403_0201, 1,  1'b1, 16'h0024, 8'd1};
        vecs[3] = '{64'h0000_0000_0000_0000, 2,  1'b1, 16'h0000, 8'd2};
        vecs[4] = '{64'hFF00_FF00_FF00_FF00, 4,  1'b1, 16'h0FF0, 8'd4};
        vecs[5] = '{64'h8040_2010_0804_0201, 2,  1'b1, 16'h01FE, 8'd2};
        vecs[6] = '{64'h8080_8080_8080_8080, 5,  1'b1, 16'h1400, 8'd5};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b1, 16'h06F8, 8'h21};
        vecs[8] = '{64'h0303_0303_0303_0303, 2,  1'b0, 16'h0030, 8'd2};

        rst_n        = 1'b0;
        io.in_pvld   = 1'b0;
        io.in_data   = '0;
        io.in_first  = 1'b0;
        io.in_last   = 1'b0;
        io.out_prdy  = 1'b1;
        sio.in_pvld  = 1'b0;
        sio.in_data  = '0;
        sio.in_first = 1'b0;
        sio.in_last  = 1'b0;
        sio.out_prdy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_pvld", 32'(io.out_pvld), 32'd0);
        check("reset_out_sum", 32'(io.out_sum), 32'd0);
        check("reset_out_cnt", 32'(io.out_cnt), 32'd0);
        check("reset_in_prdy", 32'(io.in_prdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat of 0xFF: result appears only after edge E0+3.
        exp_q.push_back({8'd1, 16'h07F8});
        io.in_pvld  = 1'b1;
        io.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        io.in_first = 1'b1;
        io.in_last  = 1'b1;
        @(posedge clk);
        #1;
        io.in_pvld  = 1'b0;
        io.in_first = 1'b0;
        io.in_last  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("latency_out_pvld", 32'(io.out_pvld), (k == 3) ? 32'd1 : 32'd0);
            if (k < 3) @(posedge clk);
        end
        @(posedge clk);
        #1;
        wait_drain();

        // Table of back-to-back groups.
        for (int v = 0; v < 9; v++) begin
            exp_q.push_back({vecs[v].exp_cnt, vecs[v].exp_sum});
            send_group(vecs[v].data, vecs[v].beats, vecs[v].use_first);
        end
        wait_drain();

        // Output stall with a further group already streaming in.
        exp_q.push_back({8'd1, 16'h0008});
        exp_q.push_back({8'd3, 16'h0030});
        io.out_prdy = 1'b0;
        fork
            begin
                send_group(64'h0101_0101_0101_0101, 1, 1'b1);
                send_group(64'h0202_0202_0202_0202, 3, 1'b1);
            end
            begin
                int w;
                w = 0;
                while (!io.out_pvld && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                check("stall_out_pvld", 32'(io.out_pvld), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    check("stall_in_prdy", 32'(io.in_prdy), 32'd0);
                    check("stall_out_sum", 32'(io.out_sum), 32'h0008);
                    check("stall_out_cnt", 32'(io.out_cnt), 32'd1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                io.out_prdy = 1'b1;
            end
        join
        wait_drain();

        // Long group: count saturates, sum wraps.
        exp_q.push_back({8'hFF, 16'h56A0});
        send_group(64'hFFFF_FFFF_FFFF_FFFF, 300, 1'b1);
        wait_drain();

        // Signed operands on the second instance.
        signed_beat(64'h8080_8080_8080_8080, 16'hFC00);
        signed_beat(64'hFFFF_FFFF_FFFF_FFFF, 16'hFFF8);

        // Reset in the middle of an open group.
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_pvld", 32'(io.out_pvld), 32'd0);
        check("midreset_out_sum", 32'(io.out_sum), 32'd0);
        check("midreset_out_cnt", 32'(io.out_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // A closing beat without first must see a cleared accumulator.
        exp_q.push_back({8'd1, 16'h0008});
        send_beat(64'h0101_0101_0101_0101, 1'b0, 1'b1);
        exp_q.push_back({8'd1, 16'h0008});
        send_beat(64'h0101_0101_0101_0101, 1'b1, 1'b1);
        wait_drain();

        repeat (10) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_out_pvld", 32'(io.out_pvld), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/nv_csa_tree_acc.md
# nv_csa_tree_acc

Pipelined, parametrised carry-save reduction tree with beat-group accumulation and a final carry-propagate add. It compresses NUM_INPUTS operands per beat through 3:2 counter levels, with configurable register insertion between levels. The carry-save pair is accumulated across a first/last-delimited group, and the resolved sum is emitted over a valid/ready interface. It sits in the CDMA/CMAC-side datapath wherever multi-operand sums over several beats are needed, such as partial-sum reduction and channel summation.

## Interface
- NUM_INPUTS, 8: operands per beat; at least 3.
- IN_WIDTH, 8: bits per operand.
- OUT_WIDTH, 16: internal and result width; must be ≥ IN_WIDTH.
- PIPE_STAGES, 2: register stages inserted in the tree, 0..L, where L is the number of 3:2 levels (L=4 for 8 inputs).
- SIGNED_IN, 0: 1 sign-extends operands, 0 zero-extends them.
- CNT_WIDTH, 8: beat counter width.

Ports:
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  reset; **asynchronous and active-low**.
- in_pvld  in  1  input beat valid.
- in_prdy  out  1  input ready.
- in_data  in  NUM_INPUTS*IN_WIDTH  operand i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- in_first  in  1  first beat of a group.
- in_last  in  1  last beat of a group.
- out_pvld  out  1  result valid.
- out_prdy  in  1  result ready.
- out_sum  out  OUT_WIDTH  group sum mod 2^OUT_WIDTH.
- out_cnt  out  CNT_WIDTH  beats in the group, saturating at all-ones.

## Operation
- Extension:
  - Each operand is sign- or zero-extended to OUT_WIDTH.
  - All arithmetic is mod 2^OUT_WIDTH.
  - A carry shifted beyond bit OUT_WIDTH-1 is discarded.
- Level reduction:
  - Each level takes n operands and groups them in threes.
  - Each group yields sum = a^b^c and carry = maj(a,b,c)<<1.
  - The n%3 leftover operands pass unchanged.
  - The next operand count is n - n/3.
  - Reduction stops at 2 operands.
- Pipeline registers are placed after levels ceil(k*L/(PIPE_STAGES+1)) for k=1..PIPE_STAGES. Each stage carries its data plus valid, first and last bits.
- Accumulator stage (registers acc0, acc1, acc_cnt):
  - On a beat with first=1, the accumulator loads the tree pair and acc_cnt loads 1.
  - On any other beat, a 4:2 compression (two 3:2 levels) of {acc0, acc1, tree0, tree1} is loaded, and acc_cnt increments, saturating.
  - On a beat with last=1:
    - The output register captures out_sum = acc0_next + acc1_next and out_cnt = acc_cnt_next.
    - out_pvld is set.
    - The accumulator clears to zero.
  - first=1 and last=1 together form a single-beat group.
  - A beat without first and without an open group accumulates onto zero.
- Flow control:
  - Global enable is en = !out_pvld | out_prdy, and in_prdy = en.
  - When en=0, every stage, the accumulator and the output hold.
  - Bubbles (in_pvld=0) propagate as invalid and do not touch the accumulator.
  - out_pvld clears on out_prdy unless a new result is captured on the same edge.
- Reset clears all stage valids, acc0, acc1, acc_cnt, out_pvld, out_sum and out_cnt to 0. Reset mid-group discards the group completely.

## Timing
- Beat acceptance happens at edge E0, when in_pvld & in_prdy.
- The accumulator updates at edge E0+PIPE_STAGES, provided there is no stall.
- The output register loads at edge E0+PIPE_STAGES+1.
- Throughput is one beat per cycle with no stall.
- Each stall cycle adds one cycle to latency.
- out_sum and out_cnt are stable while out_pvld=1 and out_prdy=0.
- in_prdy depends combinationally on out_prdy; there are no other combinational in→out paths.

## Structure
- Package nv_csa_pkg:
  - function csa32 (sum and carry of three words);
  - function csa_levels(n) giving L;
  - function csa_next(n) = n - n/3.
- Sub-module nv_csa_level:
  - one combinational 3:2 level;
  - parameters N_IN and WIDTH, producing csa_next(N_IN) outputs;
  - instantiated L times by a generate loop.
- Top level contains the stage registers, the accumulator, the CPA, the output register and the enable logic.

## Test plan
Defaults for all scenarios: NUM_INPUTS=8, IN_WIDTH=8, OUT_WIDTH=16, PIPE_STAGES=2, unsigned.
- Single beat, first=last=1, all operands 0xFF: out_sum=0x07F8 and out_cnt=1, with out_pvld rising after edge E0+3.
- Three-beat group, all operands 1, back-to-back: out_sum=0x0018 and out_cnt=3, one result only.
- SIGNED_IN=1, single beat, all operands 0x80: out_sum=0xFC00 (-1024).
- out_prdy held low for 5 cycles with a result pending:
  - in_prdy=0 and out_sum is frozen;
  - the next group completes correctly after release, with no beat lost or duplicated.
- 300-beat group of all 0xFF: out_sum=0x56A0 (612000 mod 65536) and out_cnt=0xFF (saturated).
- nvdla_core_rstn pulsed low after 2 beats of an open group, followed by a single-beat group of all 1: out_sum=0x0008 and out_cnt=1, with no stale out_pvld.
